// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock controller: holds pll_reset, waits for lock (timeout+retries), qualifies stability, releases sys_reset_n.
// pll_lock -> state is 2 cycles (synchroniser); all outputs are flops updated with the state register.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 32,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_lock,
    input  logic relock_req,
    output logic pll_reset,
    output logic sys_reset_n,
    output logic locked,
    output logic fail,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1) - 1:0] retry_count
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [RW-1:0]    retry, retry_nx;
    logic             lock_m, lock_s;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        retry_nx = retry;
        case (state)
            RST_HOLD: begin
                if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_nx = '0;
                    if (retry == RW'(MAX_RETRIES)) begin
                        state_nx = FAIL;
                    end else begin
                        state_nx = RST_HOLD;
                        retry_nx = retry + RW'(1);
                    end
                end
            end
            STABLE: begin
                // a lock dropout restarts the wait without consuming a retry
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    retry_nx = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lock_s) begin
                    state_nx = RST_HOLD;
                    retry_nx = '0;
                end
            end
            FAIL: begin
                cnt_nx = '0;
            end
            default: begin
                state_nx = RST_HOLD;
                cnt_nx   = '0;
                retry_nx = '0;
            end
        endcase
        // software relock overrides every other transition
        if (relock_req) begin
            state_nx = RST_HOLD;
            cnt_nx   = '0;
            retry_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_m      <= 1'b0;
            lock_s      <= 1'b0;
            state       <= RST_HOLD;
            cnt         <= '0;
            retry       <= '0;
            pll_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            lock_m      <= pll_lock;
            lock_s      <= lock_m;
            state       <= state_nx;
            cnt         <= cnt_nx;
            retry       <= retry_nx;
            pll_reset   <= (state_nx == RST_HOLD) || (state_nx == FAIL);
            sys_reset_n <= (state_nx == RUN);
            locked      <= (state_nx == RUN);
            fail        <= (state_nx == FAIL);
        end
    end

    assign retry_count = retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed sequence with an expectation queue; outputs packed as {pll_reset, sys_reset_n, locked, fail, retry_count}.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       locked;
    logic       fail;
    logic [1:0] retry_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (16),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .sys_reset_n(sys_reset_n),
        .locked     (locked),
        .fail       (fail),
        .retry_count(retry_count)
    );

    function automatic logic [5:0] o(input logic pr, input logic sr, input logic lk,
                                     input logic fl, input logic [1:0] rc);
        return {pr, sr, lk, fl, rc};
    endfunction

    function automatic logic [5:0] hold_v(input logic [1:0] rc);
        return o(1'b1, 1'b0, 1'b0, 1'b0, rc);
    endfunction

    function automatic logic [5:0] wait_v(input logic [1:0] rc);
        return o(1'b0, 1'b0, 1'b0, 1'b0, rc);
    endfunction

    function automatic logic [5:0] run_v();
        return o(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    endfunction

    function automatic logic [5:0] fail_v();
        return o(1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head();
        exp_t       e;
        logic [5:0] obs;
        obs = {pll_reset, sys_reset_n, locked, fail, retry_count};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%b", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic expect_next(input string tag, input logic [5:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
        tick();
        check_head();
    endtask

    // Raise pll_lock while in WAIT_LOCK; RUN appears 10 edges after the first sampling edge.
    task automatic lock_to_run(input logic [1:0] rc);
        pll_lock = 1'b1;
        for (int i = 0; i < 10; i++) expect_next("lock_qualify", wait_v(rc));
        expect_next("lock_run", run_v());
    endtask

    // Called just after the RST_HOLD entry edge of attempt a, with pll_lock low.
    task automatic run_attempt(input logic [1:0] a, input bit relock_at_timeout);
        for (int i = 0; i < 3; i++) expect_next("attempt_hold", hold_v(a));
        for (int i = 0; i < 16; i++) expect_next("attempt_wait", wait_v(a));
        if (relock_at_timeout) begin
            relock_req = 1'b1;
            expect_next("relock_on_timeout", hold_v(2'd0));
            relock_req = 1'b0;
        end else if (a == 2'd2) begin
            expect_next("attempt_fail", fail_v());
        end else begin
            expect_next("attempt_retry", hold_v(a + 2'd1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        expect_next("reset", hold_v(2'd0));
        expect_next("reset", hold_v(2'd0));

        // power-up: pll_reset high for 4 cycles, then lock after 5 cycles in WAIT_LOCK
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) expect_next("boot_hold", hold_v(2'd0));
        expect_next("boot_release", wait_v(2'd0));
        for (int i = 0; i < 4; i++) expect_next("boot_wait", wait_v(2'd0));
        lock_to_run(2'd0);
        for (int i = 0; i < 3; i++) expect_next("run_steady", run_v());

        // lock loss in RUN: resequence 2 edges later
        pll_lock = 1'b0;
        expect_next("loss_sync1", run_v());
        expect_next("loss_sync2", run_v());
        expect_next("loss_hold", hold_v(2'd0));
        for (int i = 0; i < 3; i++) expect_next("loss_hold", hold_v(2'd0));
        expect_next("loss_wait", wait_v(2'd0));

        // single-cycle lock dropout during STABLE restarts qualification
        pll_lock = 1'b1;
        for (int i = 0; i < 6; i++) expect_next("glitch_pre", wait_v(2'd0));
        pll_lock = 1'b0;
        expect_next("glitch_low", wait_v(2'd0));
        pll_lock = 1'b1;
        for (int i = 0; i < 10; i++) expect_next("glitch_requal", wait_v(2'd0));
        expect_next("glitch_run", run_v());
        expect_next("glitch_run", run_v());

        // relock request in RUN
        relock_req = 1'b1;
        expect_next("relock_in_run", hold_v(2'd0));
        relock_req = 1'b0;
        pll_lock   = 1'b0;

        // no lock: three attempts then FAIL, held
        run_attempt(2'd0, 1'b0);
        run_attempt(2'd1, 1'b0);
        run_attempt(2'd2, 1'b0);
        for (int i = 0; i < 1000; i++) expect_next("fail_held", fail_v());

        // relock from FAIL, then relock on the final timeout edge beats FAIL
        relock_req = 1'b1;
        expect_next("relock_from_fail", hold_v(2'd0));
        relock_req = 1'b0;
        run_attempt(2'd0, 1'b0);
        run_attempt(2'd1, 1'b0);
        run_attempt(2'd2, 1'b1);

        // reset mid-WAIT_LOCK with retry_count=1
        run_attempt(2'd0, 1'b0);
        for (int i = 0; i < 3; i++) expect_next("mid_hold", hold_v(2'd1));
        for (int i = 0; i < 5; i++) expect_next("mid_wait", wait_v(2'd1));
        reset_n = 1'b0;
        expect_next("mid_reset", hold_v(2'd0));
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) expect_next("restart_hold", hold_v(2'd0));
        expect_next("restart_wait", wait_v(2'd0));
        lock_to_run(2'd0);
        expect_next("final_run", run_v());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
